// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared constants and FSM encoding for the memory responder
package mem_responder_pkg;
    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] INST_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mem_responder_array.sv
// mem_array: word storage with byte-enabled synchronous write and combinational read
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [REG_BUS-1:0] wdata_i,
    input  logic [3:0]         wstrb_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [REG_BUS-1:0] rdata_o
);
    logic [REG_BUS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we_i && wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave with optional wait states
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [REG_BUS-1:0] req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               rsp_valid,
    output logic [REG_BUS-1:0] rsp_rdata,
    output logic               rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES - 1);

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, err_q, err_d, accept, load, mem_we;
    logic [31:0] addr_q, cur_addr;
    logic [REG_BUS-1:0] wdata_q, rdata_q, rdata_d, mem_rdata;
    logic [3:0] wstrb_q;
    logic cur_we;

    assign accept   = req_valid && req_ready;
    // Live inputs matter only on the accept cycle; afterwards the captured copy rules.
    assign cur_we   = (state_q == IDLE) ? req_we : we_q;
    assign cur_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign err_d    = (cur_addr[1:0] != 2'b00) || (cur_addr >= 32'(4 * DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_d   = (WAIT_CYCLES == 0) ? cnt_q : WLOAD;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers load on entry to RESP so they are visible during the RESP cycle.
    assign load    = (state_d == RESP) && (state_q != RESP);
    assign rdata_d = (load && !cur_we) ? (err_d ? INST_NOP : mem_rdata) : rdata_q;
    assign mem_we  = (state_q == RESP) && we_q && !err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= INST_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= load ? err_d : err_q;
            rdata_q <= rdata_d;
        end
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .raddr_i (cur_addr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors for three responders with 0, 2 and 3 wait states
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] vld, rdy, rv, re;
    logic req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0] req_wstrb;
    logic [31:0] rd [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));
    mem_responder #(.DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));
    mem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        err;
        logic [31:0] rd;
        string       nm;
    } vec_t;
    vec_t tv [16];

    function automatic int wt(int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic req(int k, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                       logic eerr, logic [31:0] erd, string nm);
        int n;
        chk({nm, " ready"}, 32'(rdy[k]), 32'd1);
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        vld[k] = 1'b1;
        step();
        vld[k] = 1'b0;
        n = 1;
        while (!rv[k] && n < 40) begin
            step();
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(1 + wt(k)));
        chk({nm, " err"}, 32'(re[k]), 32'(eerr));
        chk({nm, " rdata"}, rd[k], erd);
        step();
        chk({nm, " pulse"}, 32'(rv[k]), 32'd0);
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'h00, 32'h0102_0304, 4'hF, 1'b0, 32'h0000_0013, "st0"};
        tv[1]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0013, "st10"};
        tv[2]  = '{1'b0, 32'h10, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, "rd10"};
        tv[3]  = '{1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1'b0, 32'hDEAD_BEEF, "st10b0"};
        tv[4]  = '{1'b0, 32'h10, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA, "rd10b"};
        tv[5]  = '{1'b1, 32'h10, 32'h1122_3344, 4'h0, 1'b0, 32'hDEAD_BEAA, "st_nostrb"};
        tv[6]  = '{1'b0, 32'h10, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA, "rd_nostrb"};
        tv[7]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 1'b0, 32'hDEAD_BEAA, "st3c"};
        tv[8]  = '{1'b0, 32'h3C, 32'h0,         4'h0, 1'b0, 32'hCAFE_F00D, "rd3c"};
        tv[9]  = '{1'b0, 32'h12, 32'h0,         4'h0, 1'b1, 32'h0000_0013, "rd_unal"};
        tv[10] = '{1'b1, 32'h12, 32'h5555_5555, 4'hF, 1'b1, 32'h0000_0013, "st_unal"};
        tv[11] = '{1'b0, 32'h10, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA, "rd_after_unal"};
        tv[12] = '{1'b0, 32'h40, 32'h0,         4'h0, 1'b1, 32'h0000_0013, "rd_oob"};
        tv[13] = '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0013, "st_oob"};
        tv[14] = '{1'b0, 32'h00, 32'h0,         4'h0, 1'b0, 32'h0102_0304, "rd0_after_oob"};
        tv[15] = '{1'b1, 32'h3C, 32'h1122_3344, 4'hA, 1'b0, 32'h0102_0304, "st3c_mix"};

        rst = 1'b1; vld = 3'b000; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d rdata", k), rd[k], 32'h0000_0013);
            chk($sformatf("rst%0d valid", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst%0d ready", k), 32'(rdy[k]), 32'd1);
        end
        step();

        for (int i = 0; i < 16; i++)
            req(0, tv[i].we, tv[i].a, tv[i].d, tv[i].s, tv[i].err, tv[i].rd, tv[i].nm);
        req(0, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0, 32'h11FE_330D, "rd3c_mix");
        req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0000_0013, "rd_high");

        // held request is re-accepted on the IDLE cycle after RESP
        req_we = 1'b0; req_addr = 32'h10; vld[0] = 1'b1;
        step();
        chk("held rsp1", 32'(rv[0]), 32'd1);
        chk("held rdata1", rd[0], 32'hDEAD_BEAA);
        step();
        chk("held idle valid", 32'(rv[0]), 32'd0);
        chk("held idle ready", 32'(rdy[0]), 32'd1);
        step();
        vld[0] = 1'b0;
        chk("held rsp2", 32'(rv[0]), 32'd1);
        step();

        req(2, 1'b1, 32'h08, 32'h1234_5678, 4'hF, 1'b0, 32'h0000_0013, "w3 st");
        req_we = 1'b0; req_addr = 32'h08; vld[2] = 1'b1;
        step();
        req_we = 1'b1; req_wdata = 32'h0; req_wstrb = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("w3 c%0d ready", i), 32'(rdy[2]), 32'd0);
            chk($sformatf("w3 c%0d valid", i), 32'(rv[2]), 32'd0);
            chk($sformatf("w3 c%0d rdata", i), rd[2], 32'h0000_0013);
            step();
        end
        vld[2] = 1'b0;
        chk("w3 c4 valid", 32'(rv[2]), 32'd1);
        chk("w3 c4 ready", 32'(rdy[2]), 32'd0);
        chk("w3 c4 rdata", rd[2], 32'h1234_5678);
        step();
        chk("w3 c5 ready", 32'(rdy[2]), 32'd1);
        chk("w3 c5 rdata", rd[2], 32'h1234_5678);
        req(2, 1'b1, 32'h08, 32'h0BAD_0BAD, 4'hF, 1'b0, 32'h1234_5678, "w3 st2");
        req(2, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'h0BAD_0BAD, "w3 rd2");

        req(1, 1'b1, 32'h08, 32'hAAAA_AAAA, 4'hF, 1'b0, 32'h0000_0013, "w2 st");
        req(1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'hAAAA_AAAA, "w2 rd");
        req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h5555_5555; req_wstrb = 4'hF; vld[1] = 1'b1;
        step();
        vld[1] = 1'b0;
        chk("w2 inflight ready", 32'(rdy[1]), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("w2 abort valid", 32'(rv[1]), 32'd0);
        chk("w2 abort err", 32'(re[1]), 32'd0);
        chk("w2 abort ready", 32'(rdy[1]), 32'd1);
        chk("w2 abort rdata", rd[1], 32'h0000_0013);
        step(); step(); step();
        chk("w2 no late rsp", 32'(rv[1]), 32'd0);
        req(1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'hAAAA_AAAA, "w2 rd after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, range 0..15, extra wait states inserted before each response.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = fetch/load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_wstrb  input  4  store byte enables, bit i covers bits [8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse marking completion of an accepted request.
REQ-012 SHALL have port rsp_rdata  output  32  read data; held stable between read completions.
REQ-013 SHALL have port rsp_err  output  1  completion carries an error; valid only with rsp_valid.

Function
REQ-014 SHALL accept a request on a cycle where req_valid and req_ready are both 1, capturing we, addr, wdata, wstrb internally.
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL transition IDLE->RESP on accept when WAIT_CYCLES=0, IDLE->WAIT on accept otherwise; no transition without accept.
REQ-017 SHALL in WAIT load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESP the cycle after it reads 0.
REQ-018 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; total accept-to-rsp_valid latency = 1+WAIT_CYCLES cycles.
REQ-019 SHALL for reads update rsp_rdata on the RESP cycle with the word at addr[log2(DEPTH)+1:2]; rsp_rdata SHALL not change at any other time (core samples it during its EX phase and latches it).
REQ-020 SHALL for stores write only strobed bytes on the RESP cycle; rsp_rdata unchanged by stores.
REQ-021 SHALL flag error (rsp_err=1 with rsp_valid) when addr[1:0]!=0 or addr >= 4*DEPTH; errored store writes nothing; errored read drives rsp_rdata = INST_NOP (0x00000013).
REQ-022 SHALL for store with wstrb=0 complete normally with no memory change.
REQ-023 SHALL return newly written data for a read accepted any cycle after the store's RESP cycle (no stale read-after-write).
REQ-024 SHALL ignore req_valid and all req_* inputs while not in IDLE; a held request is accepted on the IDLE cycle following RESP.
REQ-025 SHALL support back-to-back requests: minimum issue interval 2+WAIT_CYCLES cycles.

Reset
REQ-026 SHALL on rst=1 at a rising edge set FSM to IDLE, wait counter to 0, rsp_valid=0, rsp_err=0, rsp_rdata=INST_NOP.
REQ-027 SHALL abort any in-flight request on reset; a store not yet in RESP SHALL not be committed.
REQ-028 SHALL not reset storage contents; req_ready=1 the first cycle after rst deasserts.

Structure
REQ-029 SHALL take INST_NOP, RegBus width and FSM state encodings from the shared defines file; no local literal for NOP.
REQ-030 SHALL contain one sub-module mem_array (DEPTH x 32, synchronous write with byte enables, combinational read); FSM, counter and output registers stay in mem_responder.

Verification
REQ-031 SHALL cover: reset then idle -> rsp_rdata=0x00000013, rsp_valid=0, req_ready=1.
REQ-032 SHALL cover: WAIT_CYCLES=0, store 0xDEADBEEF wstrb=0xF to 0x10, then read 0x10 -> rsp_valid 1 cycle after each accept, rdata=0xDEADBEEF.
REQ-033 SHALL cover: store 0x000000AA wstrb=0x1 over 0xDEADBEEF at 0x10, read -> 0xDEADBEAA.
REQ-034 SHALL cover: WAIT_CYCLES=3, read accepted cycle N -> rsp_valid only at N+4, req_ready low N+1..N+4, rdata stable until next read.
REQ-035 SHALL cover: read 0x12 and read 4*DEPTH -> rsp_err=1, rdata=0x00000013; store to 0x12 -> no memory change.
REQ-036 SHALL cover: store accepted, rst asserted during WAIT (WAIT_CYCLES=2) -> subsequent read of that address returns prior contents, outputs at reset values.
